// File: rtl/univ_shift_reg_burst.sv
// Universal shift register with single-step and counted burst shift/rotate.
module univ_shift_reg_burst #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic             shift_left_in,
  input  logic             shift_right_in,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] data_out,
  output logic             ser_out_msb,
  output logic             ser_out_lsb,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHL  = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // One register update for the given operation code.
  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] d,
    input logic [WIDTH-1:0] ld,
    input logic             sli,
    input logic             sri
  );
    logic [WIDTH-1:0] r;
    case (op)
      M_SHL:   r = {d[WIDTH-2:0], sli};
      M_SHR:   r = {sri, d[WIDTH-1:1]};
      M_LOAD:  r = ld;
      M_ROL:   r = {d[WIDTH-2:0], d[WIDTH-1]};
      M_ROR:   r = {d[0], d[WIDTH-1:1]};
      M_ASR:   r = {d[WIDTH-1], d[WIDTH-1:1]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Only shift/rotate codes can start a burst.
  function automatic logic is_burst_op(input logic [2:0] op);
    return (op != M_HOLD) && (op != M_LOAD) && (op != 3'b111);
  endfunction

  // Next-state, datapath and handshake computation.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    op_d    = op_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (en) begin
      if (state_q == IDLE) begin
        if (start && is_burst_op(mode)) begin
          op_d  = mode;
          rem_d = count;
          if (count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
          end
        end else begin
          data_d = apply_op(mode, data_q, data_in, shift_left_in, shift_right_in);
        end
      end else begin
        data_d = apply_op(op_q, data_q, data_in, shift_left_in, shift_right_in);
        rem_d  = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      op_q    <= M_HOLD;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign data_out    = data_q;
  assign ser_out_msb = data_q[WIDTH-1];
  assign ser_out_lsb = data_q[0];
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_univ_shift_reg_burst.sv
// Bench for univ_shift_reg_burst: directed scenarios plus random traffic vs. a queue model.
module tb_univ_shift_reg_burst;

  logic       clk, rst, en, shift_left_in, shift_right_in, start;
  logic [2:0] mode;
  logic [7:0] data_in;
  logic [3:0] count;
  logic [7:0] data_out;
  logic       ser_out_msb, ser_out_lsb, busy, done;

  int total = 0;
  int bad   = 0;

  // Model: register value, done flag and a queue of pending burst steps.
  logic [7:0] m_data;
  logic       m_done;
  logic [2:0] pend[$];

  univ_shift_reg_burst #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .data_in(data_in),
    .shift_left_in(shift_left_in), .shift_right_in(shift_right_in),
    .start(start), .count(count), .data_out(data_out),
    .ser_out_msb(ser_out_msb), .ser_out_lsb(ser_out_lsb),
    .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] v,
                                        input logic [7:0] ld, input logic sl, input logic sr);
    int d;
    int r;
    d = int'(v);
    case (op)
      3'b001:  r = (d * 2) % 256 + int'(sl);
      3'b010:  r = d / 2 + 128 * int'(sr);
      3'b011:  r = int'(ld);
      3'b100:  r = (d * 2) % 256 + d / 128;
      3'b101:  r = d / 2 + (d % 2) * 128;
      3'b110:  r = d / 2 + ((d >= 128) ? 128 : 0);
      default: r = d;
    endcase
    return 8'(r);
  endfunction

  function automatic bit is_shift(input logic [2:0] op);
    return op == 3'b001 || op == 3'b010 || op == 3'b100 || op == 3'b101 || op == 3'b110;
  endfunction

  task automatic model_edge();
    logic nd;
    nd = 1'b0;
    if (en) begin
      if (pend.size() > 0) begin
        m_data = ref_op(pend.pop_front(), m_data, data_in, shift_left_in, shift_right_in);
        if (pend.size() == 0) nd = 1'b1;
      end else if (start && is_shift(mode)) begin
        if (count == 4'd0) nd = 1'b1;
        for (int i = 0; i < int'(count); i++) pend.push_back(mode);
      end else begin
        m_data = ref_op(mode, m_data, data_in, shift_left_in, shift_right_in);
      end
    end
    m_done = nd;
  endtask

  task automatic model_reset();
    m_data = 8'h00;
    m_done = 1'b0;
    pend.delete();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data"}, data_out, m_data);
    chk({tag, ".msb"}, 8'(ser_out_msb), 8'(m_data[7]));
    chk({tag, ".lsb"}, 8'(ser_out_lsb), 8'(m_data[0]));
    chk({tag, ".busy"}, 8'(busy), 8'(pend.size() > 0));
    chk({tag, ".done"}, 8'(done), 8'(m_done));
  endtask

  // Advance one clock edge and compare against the model.
  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_in(input logic e, input logic [2:0] m, input logic s,
                        input logic [3:0] c, input logic [7:0] d);
    en = e; mode = m; start = s; count = c; data_in = d;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; mode = 3'b000; data_in = 8'h00; start = 1'b0;
    count = 4'd0; shift_left_in = 1'b0; shift_right_in = 1'b0;
    model_reset();
    #12;
    check_all("por");
    rst = 1'b1;
    #4;

    // 1: async reset during a burst with data FF
    set_in(1, 3'b011, 0, 0, 8'hFF); tick("rst_load");
    set_in(1, 3'b100, 1, 4'd5, 8'h00); tick("rst_start");
    set_in(1, 3'b000, 0, 0, 8'h00); tick("rst_run");
    chk("rst_pre_busy", 8'(busy), 8'h01);
    chk("rst_pre_data", data_out, 8'hFF);
    #2 rst = 1'b0;
    #1 model_reset();
    check_all("rst_async");
    chk("rst_zero", data_out, 8'h00);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) tick("rst_after");

    // 2: single step load and shift-left
    set_in(1, 3'b011, 0, 0, 8'hA5); tick("ld");
    chk("ld_val", data_out, 8'hA5);
    set_in(1, 3'b001, 0, 0, 8'h00); shift_left_in = 1'b1; tick("shl");
    chk("shl_val", data_out, 8'h4B);
    chk("shl_msb", 8'(ser_out_msb), 8'h00);
    chk("shl_lsb", 8'(ser_out_lsb), 8'h01);

    // 3: ROR burst of 3 from A5
    set_in(1, 3'b011, 0, 0, 8'hA5); tick("ror_ld");
    set_in(1, 3'b101, 1, 4'd3, 8'h00); tick("ror_start");
    set_in(1, 3'b000, 0, 0, 8'h00);
    tick("ror1"); chk("ror1_val", data_out, 8'hD2);
    tick("ror2"); chk("ror2_val", data_out, 8'h69);
    tick("ror3"); chk("ror3_val", data_out, 8'hB4);
    chk("ror_done", 8'(done), 8'h01);
    tick("ror_idle");

    // 4: ASR burst of 2 from 90, then SHR burst of 10 from FF
    set_in(1, 3'b011, 0, 0, 8'h90); tick("asr_ld");
    set_in(1, 3'b110, 1, 4'd2, 8'h00); tick("asr_start");
    set_in(1, 3'b000, 0, 0, 8'h00);
    tick("asr1"); chk("asr1_val", data_out, 8'hC8);
    tick("asr2"); chk("asr2_val", data_out, 8'hE4);
    tick("asr_idle");
    set_in(1, 3'b011, 0, 0, 8'hFF); tick("shr_ld");
    shift_right_in = 1'b0;
    set_in(1, 3'b010, 1, 4'd10, 8'h00); tick("shr_start");
    set_in(1, 3'b000, 0, 0, 8'h00);
    for (int i = 0; i < 10; i++) tick("shr_run");
    chk("shr_val", data_out, 8'h00);
    chk("shr_done", 8'(done), 8'h01);

    // 5: ROL burst with stall and ignored load/start during RUN
    set_in(1, 3'b011, 0, 0, 8'h81); tick("rol_ld");
    set_in(1, 3'b100, 1, 4'd4, 8'h00); tick("rol_start");
    set_in(1, 3'b011, 1, 4'd7, 8'h55); tick("rol1");
    set_in(0, 3'b011, 1, 4'd7, 8'h55); tick("rol_stall1"); tick("rol_stall2");
    chk("rol_frozen", data_out, 8'h03);
    set_in(1, 3'b011, 1, 4'd7, 8'h55); tick("rol2"); tick("rol3");
    set_in(1, 3'b000, 0, 0, 8'h00); tick("rol4");
    chk("rol_val", data_out, 8'h18);
    chk("rol_done", 8'(done), 8'h01);

    // 6: count=0, back-to-back start, start with load
    set_in(1, 3'b001, 1, 4'd0, 8'h00); tick("c0");
    chk("c0_done", 8'(done), 8'h01);
    chk("c0_data", data_out, 8'h18);
    set_in(1, 3'b000, 0, 0, 8'h00); tick("c0_after");
    set_in(1, 3'b100, 1, 4'd1, 8'h00); tick("b2b_s1"); tick("b2b_1");
    chk("b2b_done1", 8'(done), 8'h01);
    set_in(1, 3'b101, 1, 4'd2, 8'h00); tick("b2b_s2");
    chk("b2b_busy2", 8'(busy), 8'h01);
    set_in(1, 3'b000, 0, 0, 8'h00); tick("b2b_2a"); tick("b2b_2b");
    set_in(1, 3'b011, 1, 4'd3, 8'h3C); tick("ld_start");
    chk("ld_start_val", data_out, 8'h3C);
    chk("ld_start_done", 8'(done), 8'h00);

    // Random traffic with occasional async reset
    for (int n = 0; n < 400; n++) begin
      en = ($urandom_range(0, 9) < 8);
      mode = 3'($urandom_range(0, 7));
      start = ($urandom_range(0, 9) < 3);
      count = 4'($urandom_range(0, 15));
      data_in = 8'($urandom);
      shift_left_in = 1'($urandom);
      shift_right_in = 1'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b0;
        #1 model_reset();
        check_all("rnd_rst");
        rst = 1'b1;
      end
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
